// File: rtl/learning_pkg.sv
// Shared state codes and constants for the piano learning-mode sequencer.
package learning_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_PLAY    = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;
  localparam logic [2:0] ST_ADVANCE = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam int unsigned REST_NOTE = 0;

  localparam logic MODE_FREE   = 1'b0;
  localparam logic MODE_STRICT = 1'b1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/learn_timer.sv
// Loadable down-counter; expired is registered and mirrors count==0.
module learn_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         enable,
  output logic         expired
);

  logic [W-1:0] count;

  // Holds at zero once reached, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      expired <= 1'b1;
    end else if (load) begin
      count   <= value;
      expired <= (value == '0);
    end else if (enable && (count != '0)) begin
      count   <= count - W'(1);
      expired <= (count == W'(1));
    end
  end

endmodule

// File: rtl/learning_sequencer.sv
// Learning-mode engine: waits for the matching key per note, plays it, then a gap.
module learning_sequencer
  import learning_pkg::*;
#(
  parameter int unsigned NOTE_W         = 4,
  parameter int unsigned DUR_W          = 26,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned SONG_LEN       = 26,
  parameter int unsigned GAP_CYCLES     = 50000000,
  parameter int unsigned TIMEOUT_CYCLES = 500000000,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned SCORE_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [NOTE_W-1:0] note_value,
  input  logic [DUR_W-1:0]  duration_value,
  input  logic [NOTE_W-1:0] user_input,
  input  logic              user_valid,
  output logic [ADDR_W-1:0] addr,
  output logic              key_on,
  output logic [NOTE_W-1:0] key,
  output logic [SCORE_W-1:0] score,
  output logic              hit,
  output logic              miss,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = max3(DUR_W, $clog2(GAP_CYCLES), $clog2(TIMEOUT_CYCLES));
  localparam int unsigned TRY_W = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);
  localparam logic [CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]         state, state_n;
  logic [ADDR_W-1:0]  addr_n;
  logic [SCORE_W-1:0] score_n;
  logic [TRY_W-1:0]   tries, tries_n, tries_inc;
  logic               mode_r, mode_n;
  logic [NOTE_W-1:0]  note_r, note_n, key_n;
  logic [DUR_W-1:0]   dur_r, dur_n;
  logic               key_on_n, hit_n, miss_n, busy_n, done_n;
  logic               tmr_load, tmr_en, tmr_expired;
  logic [CNT_W-1:0]   tmr_value;

  // A zero duration still sounds for one cycle.
  function automatic logic [CNT_W-1:0] play_len(input logic [DUR_W-1:0] d);
    return (d == '0) ? '0 : CNT_W'(d - DUR_W'(1));
  endfunction

  learn_timer #(.W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      addr   <= '0;
      key_on <= 1'b0;
      key    <= '0;
      score  <= '0;
      hit    <= 1'b0;
      miss   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      tries  <= '0;
      mode_r <= MODE_FREE;
      note_r <= '0;
      dur_r  <= '0;
    end else begin
      state  <= state_n;
      addr   <= addr_n;
      key_on <= key_on_n;
      key    <= key_n;
      score  <= score_n;
      hit    <= hit_n;
      miss   <= miss_n;
      busy   <= busy_n;
      done   <= done_n;
      tries  <= tries_n;
      mode_r <= mode_n;
      note_r <= note_n;
      dur_r  <= dur_n;
    end
  end

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    score_n   = score;
    tries_n   = tries;
    mode_n    = mode_r;
    note_n    = note_r;
    dur_n     = dur_r;
    hit_n     = 1'b0;
    miss_n    = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_en    = 1'b0;
    tries_inc = (tries == '1) ? tries : tries + TRY_W'(1);

    case (state)
      ST_IDLE, ST_DONE: ;
      ST_FETCH: begin
        note_n   = note_value;
        dur_n    = duration_value;
        tmr_load = 1'b1;
        if (note_value == NOTE_W'(REST_NOTE)) begin
          state_n   = ST_PLAY;
          tmr_value = play_len(duration_value);
        end else begin
          state_n   = ST_WAIT;
          tmr_value = TIMEOUT_LOAD;
        end
      end
      ST_WAIT: begin
        tmr_en = 1'b1;
        // A press on the timeout cycle takes priority over the timeout.
        if (user_valid) begin
          if (user_input == note_r) begin
            hit_n     = 1'b1;
            score_n   = (score == '1) ? score : score + SCORE_W'(1);
            state_n   = ST_PLAY;
            tmr_load  = 1'b1;
            tmr_value = play_len(dur_r);
          end else begin
            miss_n  = 1'b1;
            tries_n = tries_inc;
            if ((mode_r == MODE_STRICT) && (32'(tries_inc) >= MAX_TRIES)) begin
              state_n = ST_ADVANCE;
            end
          end
        end else if ((mode_r == MODE_STRICT) && tmr_expired) begin
          miss_n  = 1'b1;
          state_n = ST_ADVANCE;
        end
      end
      ST_PLAY: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
          if (GAP_CYCLES == 0) begin
            state_n = ST_ADVANCE;
          end else begin
            state_n   = ST_GAP;
            tmr_load  = 1'b1;
            tmr_value = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        tmr_en = 1'b1;
        if (tmr_expired) state_n = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        tries_n = '0;
        if (addr == ADDR_W'(SONG_LEN - 1)) begin
          state_n = ST_DONE;
        end else begin
          addr_n  = addr + ADDR_W'(1);
          state_n = ST_FETCH;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // start from any state (re)launches the song from the first note.
    if (start) begin
      state_n = ST_FETCH;
      addr_n  = '0;
      score_n = '0;
      tries_n = '0;
      mode_n  = mode;
      hit_n   = 1'b0;
      miss_n  = 1'b0;
    end

    key_on_n = (state_n == ST_PLAY) && (note_n != NOTE_W'(REST_NOTE));
    key_n    = ((state_n == ST_PLAY) || (state_n == ST_GAP)) ? note_n : '0;
    busy_n   = (state_n != ST_IDLE) && (state_n != ST_DONE);
    done_n   = (state_n == ST_DONE);
  end

endmodule

// File: tb/tb_learning_sequencer.sv
// Directed bench for learning_sequencer: cycle table for a full free-mode song plus corner sequences.
module tb_learning_sequencer;

  logic       clk, rst, start, mode, user_valid;
  logic [3:0] note_value, user_input, key;
  logic [7:0] duration_value;
  logic [4:0] addr;
  logic       key_on, hit, miss, busy, done;
  logic [1:0] score;
  logic [15:0] outs;

  logic [3:0] mem_note [4];
  logic [7:0] mem_dur  [4];

  int tests = 0;
  int failed = 0;

  learning_sequencer #(
    .NOTE_W(4), .DUR_W(8), .ADDR_W(5), .SONG_LEN(4), .GAP_CYCLES(3),
    .TIMEOUT_CYCLES(10), .MAX_TRIES(2), .SCORE_W(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .note_value(note_value), .duration_value(duration_value),
    .user_input(user_input), .user_valid(user_valid),
    .addr(addr), .key_on(key_on), .key(key), .score(score),
    .hit(hit), .miss(miss), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Song memory presenting data for the current address.
  always_comb begin
    note_value     = '0;
    duration_value = '0;
    if (addr < 5'd4) begin
      note_value     = mem_note[addr[1:0]];
      duration_value = mem_dur[addr[1:0]];
    end
  end

  assign outs = {addr, key_on, key, score, hit, miss, busy, done};

  typedef struct {
    logic        st;
    logic        md;
    logic        uv;
    logic [3:0]  ui;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [15:0] o(input logic [4:0] a, input logic kon, input logic [3:0] k,
                                    input logic [1:0] sc, input logic h, input logic m,
                                    input logic b, input logic d);
    return {a, kon, k, sc, h, m, b, d};
  endfunction

  task automatic add(input logic st, input logic md, input logic uv, input logic [3:0] ui,
                     input logic [15:0] e);
    vec_t v;
    v.st = st; v.md = md; v.uv = uv; v.ui = ui; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic md, input logic v, input logic [3:0] u);
    start = s; mode = md; user_valid = v; user_input = u;
    @(posedge clk);
    #1;
    start = 1'b0; user_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  // Press the right key and count how many cycles key_on stays high.
  task automatic hit_note(input logic [3:0] u, output int on);
    step(1'b0, 1'b0, 1'b1, u);
    chk("hit_pulse", 32'(hit), 32'd1);
    on = 0;
    while (key_on === 1'b1 && on < 50) begin
      on++;
      idle(1);
    end
  endtask

  initial begin
    int on, early, nmiss, kmax;
    int exp_on [4];

    rst = 1'b1; start = 1'b0; mode = 1'b0; user_valid = 1'b0; user_input = '0;
    mem_note[0] = 4'd5; mem_dur[0] = 8'd4;
    mem_note[1] = 4'd7; mem_dur[1] = 8'd2;
    mem_note[2] = 4'd0; mem_dur[2] = 8'd3;
    mem_note[3] = 4'd1; mem_dur[3] = 8'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 32'(outs), 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_over_start", 32'(outs), 32'd0);
    start = 1'b0;
    rst = 1'b0;

    // Free mode song {5/4, 7/2, 0/3, 1/1}, one row per clock.
    add(1, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 1, 0));
    add(0, 0, 1, 5, o(0, 1, 5, 1, 1, 0, 1, 0));
    add(0, 0, 1, 5, o(0, 1, 5, 1, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(0, 1, 5, 1, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(0, 1, 5, 1, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(0, 0, 5, 1, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(0, 0, 5, 1, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(0, 0, 5, 1, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(0, 0, 0, 1, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(1, 0, 0, 1, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(1, 0, 0, 1, 0, 0, 1, 0));
    add(0, 0, 1, 7, o(1, 1, 7, 2, 1, 0, 1, 0));
    add(0, 0, 0, 0, o(1, 1, 7, 2, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(1, 0, 7, 2, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(1, 0, 7, 2, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(1, 0, 7, 2, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(1, 0, 0, 2, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(2, 0, 0, 2, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(2, 0, 0, 2, 0, 0, 1, 0));
    add(0, 0, 1, 7, o(2, 0, 0, 2, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(2, 0, 0, 2, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(2, 0, 0, 2, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(2, 0, 0, 2, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(2, 0, 0, 2, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(2, 0, 0, 2, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(3, 0, 0, 2, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(3, 0, 0, 2, 0, 0, 1, 0));
    add(0, 0, 1, 1, o(3, 1, 1, 3, 1, 0, 1, 0));
    add(0, 0, 0, 0, o(3, 0, 1, 3, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(3, 0, 1, 3, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(3, 0, 1, 3, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(3, 0, 0, 3, 0, 0, 1, 0));
    add(0, 0, 0, 0, o(3, 0, 0, 3, 0, 0, 0, 1));
    add(0, 0, 0, 0, o(3, 0, 0, 3, 0, 0, 0, 1));
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].st, vecs[i].md, vecs[i].uv, vecs[i].ui);
      chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
    end

    // Strict: two wrong presses skip note 0 with no sound and no score.
    step(1'b1, 1'b1, 1'b0, 4'd0);
    idle(1);
    step(1'b0, 1'b0, 1'b1, 4'd3);
    chk("strict_miss1", 32'({hit, miss, key_on}), 32'b010);
    step(1'b0, 1'b0, 1'b1, 4'd3);
    chk("strict_miss2", 32'({hit, miss, key_on}), 32'b010);
    idle(1);
    chk("strict_skip_addr", 32'(addr), 32'd1);
    chk("strict_score", 32'(score), 32'd0);

    // Strict timeout on note 7 at addr 1.
    idle(1);
    early = 0;
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      if (k < 10) early += 32'(miss);
      else chk("timeout_miss", 32'({hit, miss}), 32'b01);
    end
    chk("timeout_early", 32'(early), 32'd0);
    idle(1);
    chk("timeout_next_addr", 32'(addr), 32'd2);

    // Correct press on the timeout cycle wins.
    step(1'b1, 1'b1, 1'b0, 4'd0);
    idle(1);
    idle(9);
    step(1'b0, 1'b0, 1'b1, 4'd5);
    chk("press_beats_timeout", 32'({hit, miss, key_on}), 32'b101);

    // Free mode: 20 wrong presses never skip.
    step(1'b1, 1'b0, 1'b0, 4'd0);
    idle(1);
    nmiss = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'd2);
      nmiss += 32'(miss);
    end
    chk("free_misses", 32'(nmiss), 32'd20);
    step(1'b0, 1'b0, 1'b1, 4'd5);
    chk("free_hit", 32'({hit, miss, score, addr}), {25'd0, 1'b1, 1'b0, 2'd1, 5'd0});

    // Rest first, zero duration, then abort mid-PLAY at addr 2.
    mem_note[0] = 4'd0; mem_dur[0] = 8'd1;
    mem_note[1] = 4'd5; mem_dur[1] = 8'd0;
    mem_note[2] = 4'd3; mem_dur[2] = 8'd6;
    mem_note[3] = 4'd9; mem_dur[3] = 8'd2;
    step(1'b1, 1'b0, 1'b0, 4'd0);
    kmax = 0;
    for (int i = 0; i < 7; i++) begin
      idle(1);
      kmax |= 32'(key_on);
    end
    chk("rest_silent", 32'(kmax), 32'd0);
    chk("rest_auto_adv", 32'(addr), 32'd1);
    hit_note(4'd5, on);
    chk("dur0_one_cycle", 32'(on), 32'd1);
    idle(5);
    chk("reach_addr2", 32'(addr), 32'd2);
    step(1'b0, 1'b0, 1'b1, 4'd3);
    chk("play_addr2", 32'({key_on, score}), 32'b110);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("abort", 32'({key_on, score, addr, busy}), 32'b0_00_00000_1);

    // Four hits saturate a 2-bit score.
    mem_note[0] = 4'd5; mem_dur[0] = 8'd2; exp_on[0] = 2;
    mem_note[1] = 4'd7; mem_dur[1] = 8'd1; exp_on[1] = 1;
    mem_note[2] = 4'd3; mem_dur[2] = 8'd1; exp_on[2] = 1;
    mem_note[3] = 4'd9; mem_dur[3] = 8'd1; exp_on[3] = 1;
    step(1'b1, 1'b0, 1'b0, 4'd0);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      hit_note(mem_note[i], on);
      chk($sformatf("on_len%0d", i), 32'(on), 32'(exp_on[i]));
      idle(i < 3 ? 5 : 4);
    end
    chk("score_sat", 32'({done, busy, score, addr}), {23'd0, 1'b1, 1'b0, 2'd3, 5'd3});

    // Synchronous reset in the middle of a gap.
    step(1'b1, 1'b0, 1'b0, 4'd0);
    idle(1);
    hit_note(4'd5, on);
    chk("gap_key", 32'({key_on, key}), 32'h05);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_gap", 32'(outs), 32'd0);
    rst = 1'b0;
    idle(2);
    chk("idle_after_rst", 32'(outs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/learning_sequencer.md
Name: learning_sequencer

Overview:
Parametrised next-generation learning-mode engine for the piano. It steps through a song stored in an external note/duration memory and waits at each note for the player to press the matching key. On a correct press it sounds the note for its stored duration, then inserts a silent gap before moving on. Adds rests, a strict mode with per-note retry limit and timeout, saturating scoring, and hit/miss/done status for the display and score logic.

Parameters:
NOTE_W, 4, width of note code; code 0 = rest/silence
DUR_W, 26, width of duration field, in clk cycles
ADDR_W, 5, song memory address width
SONG_LEN, 26, notes per song; must be <= 2**ADDR_W
GAP_CYCLES, 50000000, silent cycles after each note
TIMEOUT_CYCLES, 500000000, strict-mode wait limit per note
MAX_TRIES, 3, strict-mode wrong presses allowed before the note is skipped
SCORE_W, 8, score width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins or restarts a song
mode  in  1  0 = free (no limits), 1 = strict (tries and timeout); sampled on start
note_value  in  NOTE_W  memory data: note at addr, valid 1 cycle after addr changes
duration_value  in  DUR_W  memory data: duration at addr, same timing as note_value
user_input  in  NOTE_W  key code from keyboard decoder
user_valid  in  1  one-cycle pulse per debounced key press
addr  out  ADDR_W  song memory address
key_on  out  1  buzzer enable
key  out  NOTE_W  note to buzzer
score  out  SCORE_W  notes hit this song, saturating
hit  out  1  one-cycle pulse on correct press
miss  out  1  one-cycle pulse on wrong press, timeout, or skip
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE

Behaviour:
- Reset: state IDLE; addr=0, key_on=0, key=0, score=0, hit=0, miss=0, busy=0, done=0; counters and tries cleared. rst overrides start.
- All outputs are registered. hit and miss are single-cycle pulses.
- IDLE: on start, clear score, clear tries, set addr=0, latch mode, go to FETCH.
- FETCH (1 cycle): latch note_value/duration_value into internal registers. Next state:
  - latched note==0 (rest) -> PLAY, with key_on held 0.
  - otherwise -> WAIT.
- WAIT: key_on=0, key=0. Timer counts cycles.
  - user_valid and user_input==note: hit pulse; score+1, saturating at all-ones; go to PLAY.
  - user_valid and wrong input: miss pulse; tries+1. In strict mode, when tries reaches MAX_TRIES, go to ADVANCE with no score change.
  - Strict mode, timer reaches TIMEOUT_CYCLES-1 with no press: miss pulse; go to ADVANCE.
  - Free mode: no timeout and unlimited tries.
  - A user_valid on the same cycle as the timeout: the press wins.
- PLAY: key=note; key_on=1 (key_on=0 for a rest) for max(duration,1) cycles, then go to GAP. user_valid is ignored.
- GAP: key_on=0, key=note, for GAP_CYCLES cycles (0 means skip the gap), then go to ADVANCE.
- ADVANCE (1 cycle): key=0; tries cleared.
  - addr==SONG_LEN-1 -> DONE; addr stays.
  - otherwise addr+1 -> FETCH.
- DONE: done=1, score held. start -> restart exactly as from IDLE.
- start in any busy state aborts the current song immediately: key_on drops the next cycle, score is cleared, and the song restarts at FETCH with addr=0.
- Counter width: max of DUR_W and clog2 of GAP_CYCLES and TIMEOUT_CYCLES. No wrap in any state.

Decomposition:
- Package learning_pkg holds:
  - state enum {IDLE, FETCH, WAIT, PLAY, GAP, ADVANCE, DONE}
  - REST_NOTE=0
  - mode constants MODE_FREE=0, MODE_STRICT=1
- One sub-module, learn_timer: loadable down-counter with load value, enable, and a registered expire flag. Shared by the WAIT, PLAY, and GAP states.

Test Plan:
- Setup for all scenarios: SONG_LEN=4, GAP_CYCLES=3, TIMEOUT_CYCLES=10, MAX_TRIES=2.
- Free mode, song {5/4, 7/2, 0/3, 1/1}, correct presses -> key_on high 4, 2, 0, 1 cycles for the notes; the rest auto-advances with no press; score=3; done after addr=3; addr never reaches 4.
- Strict mode, note 5, presses 3 then 3 -> two miss pulses; advance to addr=1 with no key_on; score unchanged.
- Strict mode, no press for 10 cycles -> miss pulse on cycle 10 of WAIT; next FETCH at addr+1. Same test with user_valid=5 on the timeout cycle -> hit, no miss.
- Free mode, 20 wrong presses then a correct one -> 20 misses, 1 hit, score=1, no skip.
- start pulse mid-PLAY at addr=2 with score=2 -> key_on=0 next cycle; score=0; addr=0. rst mid-GAP -> all outputs reach reset values on the next edge.
- SCORE_W=2, 4 hits -> score saturates at 3. duration_value=0 -> key_on high exactly 1 cycle.
